nlc_lin_serializer: RTL and testbench

- Downstream stage of the 16-channel NLC core.
- Captures the 16 parallel 21-bit linearized results on each NLC output strobe (srdyo) into a 2-deep ping-pong frame buffer.
- Streams the captured frames out one channel per cycle over a valid/ready interface to the readout/capture logic.
- Counts accepted frames and flags frames it has to drop.

---
 rtl/nlc_lin_serializer.sv | 129 ++++++++++++
 tb/tb_nlc_lin_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nlc_lin_serializer.sv
// Ping-pong frame buffer behind the 16-channel NLC core: captures parallel
// linearized frames on srdyi and streams them one channel per cycle.
module nlc_lin_serializer #(
    parameter int NCH = 16,
    parameter int DW  = 21,
    parameter int FCW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              srdyi,
    input  logic [NCH*DW-1:0] x_lin_i,
    output logic [DW-1:0]     dout,
    output logic [3:0]        ch_id,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              sof,
    output logic              eof,
    output logic [FCW-1:0]    frame_cnt,
    output logic [7:0]        drop_cnt,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [3:0] LAST_CH = 4'(NCH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [3:0]       ch_id_q, ch_id_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic [NCH*DW-1:0] buf_q [2];

    logic pop, pop_last, accept, drop;

    always_comb begin
        pop      = (state_q == STREAM) && dout_ready;
        pop_last = pop && (ch_id_q == LAST_CH);
        // When both slots are full, wr_ptr equals rd_ptr, so a pop_last frees
        // exactly the slot the incoming frame is about to be written into.
        accept   = srdyi && (!full_q[wr_ptr_q] || pop_last);
        drop     = srdyi && !accept;

        full_d = full_q;
        if (pop_last) full_d[rd_ptr_q] = 1'b0;
        if (accept)   full_d[wr_ptr_q] = 1'b1;

        wr_ptr_d    = accept ? ~wr_ptr_q : wr_ptr_q;
        frame_cnt_d = accept ? frame_cnt_q + FCW'(1) : frame_cnt_q;

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = ovf_clr ? 8'd1 : sat_inc8(drop_cnt_q);
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end

        state_d  = state_q;
        ch_id_d  = ch_id_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            IDLE: begin
                ch_id_d = 4'd0;
                if (|full_d) state_d = STREAM;
            end
            STREAM: begin
                if (pop_last) begin
                    rd_ptr_d = ~rd_ptr_q;
                    ch_id_d  = 4'd0;
                    state_d  = full_d[~rd_ptr_q] ? STREAM : IDLE;
                end else if (pop) begin
                    ch_id_d = ch_id_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            full_q      <= 2'b00;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ch_id_q     <= 4'd0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= 8'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ch_id_q     <= ch_id_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Frame storage carries no reset; occupancy flags alone decide validity.
    always_ff @(posedge clk) begin
        if (accept) buf_q[wr_ptr_q] <= x_lin_i;
    end

    always_comb begin
        dout_valid = (state_q == STREAM);
        dout       = dout_valid ? buf_q[rd_ptr_q][int'(ch_id_q)*DW +: DW] : '0;
        ch_id      = dout_valid ? ch_id_q : 4'd0;
        sof        = dout_valid && (ch_id_q == 4'd0);
        eof        = dout_valid && (ch_id_q == LAST_CH);
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nlc_lin_serializer.sv
// Directed bench for nlc_lin_serializer: inputs change and outputs are
// sampled on the falling clock edge.
module tb_nlc_lin_serializer;

    localparam int NCH = 16;
    localparam int DW  = 21;
    localparam int FCW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              srdyi;
    logic [NCH*DW-1:0] x_lin_i;
    logic [DW-1:0]     dout;
    logic [3:0]        ch_id;
    logic              dout_valid;
    logic              dout_ready;
    logic              sof;
    logic              eof;
    logic [FCW-1:0]    frame_cnt;
    logic [7:0]        drop_cnt;
    logic              overflow;
    logic              ovf_clr;

    int errors = 0;
    int checks = 0;

    nlc_lin_serializer #(.NCH(NCH), .DW(DW), .FCW(FCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .srdyi     (srdyi),
        .x_lin_i   (x_lin_i),
        .dout      (dout),
        .ch_id     (ch_id),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .sof       (sof),
        .eof       (eof),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NCH*DW-1:0] mk_frame(input logic [DW-1:0] base);
        logic [NCH*DW-1:0] f;
        for (int n = 0; n < NCH; n++) f[n*DW +: DW] = base + DW'(n);
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] exp_d, input int exp_ch);
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check({tag, "_dout"},  32'(dout),       32'(exp_d));
        check({tag, "_ch"},    32'(ch_id),      32'(exp_ch));
        check({tag, "_sof"},   32'(sof),        32'(exp_ch == 0));
        check({tag, "_eof"},   32'(eof),        32'(exp_ch == NCH - 1));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int vcnt;
        int cyc;
        logic r;

        reset = 1'b0; srdyi = 1'b0; x_lin_i = '0; dout_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_ch",    32'(ch_id),      32'd0);
        check("rst_sof",   32'(sof),        32'd0);
        check("rst_eof",   32'(eof),        32'd0);
        check("rst_fcnt",  32'(frame_cnt),  32'd0);
        check("rst_dcnt",  32'(drop_cnt),   32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        reset = 1'b1;
        tick();

        // Single frame, no back-pressure; first word the cycle after srdyi
        srdyi = 1'b1; x_lin_i = mk_frame(21'h100000); dout_ready = 1'b1;
        tick();
        srdyi = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            chk_word("single", 21'h100000 + 21'(i), i);
            tick();
        end
        check("single_end_valid", 32'(dout_valid), 32'd0);
        check("single_fcnt",      32'(frame_cnt),  32'd1);

        // Back-pressure: ready toggles 1,0,1,0 starting with the first valid word
        srdyi = 1'b1; x_lin_i = mk_frame(21'h200000);
        tick();
        srdyi = 1'b0;
        idx = 0; vcnt = 0; cyc = 0; r = 1'b1;
        while (idx < NCH && cyc < 80) begin
            dout_ready = r;
            if (dout_valid) begin
                check("bp_dout", 32'(dout),  32'(21'h200000 + 21'(idx)));
                check("bp_ch",   32'(ch_id), 32'(idx));
                if (r) idx++;
                vcnt++;
            end
            tick();
            r = ~r;
            cyc++;
        end
        check("bp_words",  32'(idx),        32'd16);
        check("bp_cycles", 32'(vcnt),       32'd31);
        check("bp_end",    32'(dout_valid), 32'd0);
        check("bp_fcnt",   32'(frame_cnt),  32'd2);

        // Overflow: A and B stored, C dropped while the consumer stalls
        dout_ready = 1'b0;
        srdyi = 1'b1; x_lin_i = mk_frame(21'h030000);
        tick();
        x_lin_i = mk_frame(21'h040000);
        tick();
        x_lin_i = mk_frame(21'h050000);
        tick();
        srdyi = 1'b0;
        check("ovf_fcnt", 32'(frame_cnt), 32'd4);
        check("ovf_dcnt", 32'(drop_cnt),  32'd1);
        check("ovf_flag", 32'(overflow),  32'd1);
        dout_ready = 1'b1;
        for (int i = 0; i < 2 * NCH; i++) begin
            chk_word("ovf_ab", (i < NCH) ? 21'h030000 + 21'(i) : 21'h040000 + 21'(i - NCH), i % NCH);
            tick();
        end
        check("ovf_ab_end", 32'(dout_valid), 32'd0);

        // Frame arriving on the very cycle the last word of a full buffer pair pops
        dout_ready = 1'b0;
        srdyi = 1'b1; x_lin_i = mk_frame(21'h060000);
        tick();
        x_lin_i = mk_frame(21'h070000);
        tick();
        srdyi = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < NCH - 1; i++) begin
            chk_word("reuse_d", 21'h060000 + 21'(i), i);
            tick();
        end
        chk_word("reuse_dlast", 21'h06000F, NCH - 1);
        srdyi = 1'b1; x_lin_i = mk_frame(21'h080000);
        tick();
        srdyi = 1'b0;
        check("reuse_fcnt", 32'(frame_cnt), 32'd7);
        check("reuse_dcnt", 32'(drop_cnt),  32'd1);
        for (int i = 0; i < 2 * NCH; i++) begin
            chk_word("reuse_ef", (i < NCH) ? 21'h070000 + 21'(i) : 21'h080000 + 21'(i - NCH), i % NCH);
            tick();
        end
        check("reuse_end", 32'(dout_valid), 32'd0);

        // ovf_clr racing a drop, then ovf_clr alone
        dout_ready = 1'b0;
        srdyi = 1'b1; x_lin_i = mk_frame(21'h0A0000);
        tick();
        x_lin_i = mk_frame(21'h0B0000);
        tick();
        x_lin_i = mk_frame(21'h0C0000);
        tick();
        check("clr_pre_dcnt", 32'(drop_cnt), 32'd2);
        x_lin_i = mk_frame(21'h0D0000); ovf_clr = 1'b1;
        tick();
        srdyi = 1'b0;
        check("clr_race_dcnt", 32'(drop_cnt), 32'd1);
        check("clr_race_ovf",  32'(overflow), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("clr_dcnt", 32'(drop_cnt),  32'd0);
        check("clr_ovf",  32'(overflow),  32'd0);
        check("clr_fcnt", 32'(frame_cnt), 32'd9);
        chk_word("clr_held", 21'h0A0000, 0);
        dout_ready = 1'b1;
        repeat (2 * NCH) tick();
        check("clr_drain", 32'(dout_valid), 32'd0);

        // Asynchronous reset in the middle of a frame
        srdyi = 1'b1; x_lin_i = mk_frame(21'h0E0000);
        tick();
        srdyi = 1'b0;
        repeat (7) tick();
        chk_word("arst_pre", 21'h0E0007, 7);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_ch",    32'(ch_id),      32'd0);
        check("arst_fcnt",  32'(frame_cnt),  32'd0);
        check("arst_dcnt",  32'(drop_cnt),   32'd0);
        check("arst_ovf",   32'(overflow),   32'd0);
        tick();
        reset = 1'b1;
        srdyi = 1'b1; x_lin_i = mk_frame(21'h0F0000);
        tick();
        srdyi = 1'b0;
        chk_word("arst_new", 21'h0F0000, 0);
        check("arst_new_fcnt", 32'(frame_cnt), 32'd1);
        tick();
        chk_word("arst_new1", 21'h0F0001, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
